// File: rtl/aluout_seq_ctrl_pkg.sv
// Shared ALUOut control codes: op classes, mux selects, shifter commands, sequencer states.
// Used by the main control unit, the ALUOut mux/shifter wiring and the execute sequencer.
package aluout_seq_ctrl_pkg;

  localparam logic [2:0] OP_ALU     = 3'b000;
  localparam logic [2:0] OP_AUX     = 3'b001;
  localparam logic [2:0] OP_SLT_EXT = 3'b010;
  localparam logic [2:0] OP_SLL     = 3'b011;
  localparam logic [2:0] OP_SRL     = 3'b100;
  localparam logic [2:0] OP_SRA     = 3'b101;

  localparam logic [1:0] SEL_AUX    = 2'b00;
  localparam logic [1:0] SEL_ALU    = 2'b01;
  localparam logic [1:0] SEL_SHIFT  = 2'b10;
  localparam logic [1:0] SEL_EXT    = 2'b11;

  localparam logic [2:0] SH_HOLD    = 3'b000;
  localparam logic [2:0] SH_LOAD    = 3'b001;
  localparam logic [2:0] SH_SHL     = 3'b010;
  localparam logic [2:0] SH_SHR     = 3'b011;
  localparam logic [2:0] SH_SAR     = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_SRA;
  endfunction

  function automatic logic op_is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic [1:0] write_sel(input logic [2:0] op);
    case (op)
      OP_ALU:     return SEL_ALU;
      OP_AUX:     return SEL_AUX;
      OP_SLT_EXT: return SEL_EXT;
      default:    return SEL_SHIFT;
    endcase
  endfunction

  function automatic logic [2:0] shift_cmd(input logic [2:0] op);
    case (op)
      OP_SLL:  return SH_SHL;
      OP_SRL:  return SH_SHR;
      default: return SH_SAR;
    endcase
  endfunction

endpackage

// File: rtl/aluout_seq_ctrl.sv
// Execute-stage sequencer for the ALUOut mux/register and shifter; one write + done per request.
// Latency: ALU classes 1+ALU_SETTLE cycles, shifts 3 (2 when shamt==0); all outputs registered.
// No backpressure: start is only sampled in IDLE and dropped while busy; illegal ops pulse err.
module aluout_seq_ctrl
  import aluout_seq_ctrl_pkg::*;
#(
  parameter int ALU_SETTLE = 0,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [4:0] shamt,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] alu_out_sel,
  output logic       alu_out_load,
  output logic [2:0] shift_ctrl,
  output logic [4:0] shift_n
);

  state_t           state;
  logic [2:0]       op_q;
  logic [4:0]       shamt_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      shamt_q      <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      alu_out_sel  <= SEL_ALU;
      alu_out_load <= 1'b0;
      shift_ctrl   <= SH_HOLD;
      shift_n      <= '0;
    end else begin
      // Outputs are decoded for the state being entered, so they line up with it.
      done         <= 1'b0;
      err          <= 1'b0;
      alu_out_sel  <= SEL_ALU;
      alu_out_load <= 1'b0;
      shift_ctrl   <= SH_HOLD;
      shift_n      <= '0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start && !op_is_legal(op)) begin
            err <= 1'b1;
          end else if (start) begin
            op_q    <= op;
            shamt_q <= shamt;
            busy    <= 1'b1;
            if (op_is_shift(op)) begin
              state      <= ST_LOAD;
              shift_ctrl <= SH_LOAD;
            end else if (ALU_SETTLE > 0) begin
              state <= ST_SETTLE;
              cnt   <= CNT_W'(ALU_SETTLE - 1);
            end else begin
              state        <= ST_WRITE;
              alu_out_sel  <= write_sel(op);
              alu_out_load <= 1'b1;
              done         <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          busy <= 1'b1;
          if (cnt == '0) begin
            state        <= ST_WRITE;
            alu_out_sel  <= write_sel(op_q);
            alu_out_load <= 1'b1;
            done         <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_LOAD: begin
          busy <= 1'b1;
          if (shamt_q != '0) begin
            state      <= ST_SHIFT;
            shift_ctrl <= shift_cmd(op_q);
            shift_n    <= shamt_q;
          end else begin
            state        <= ST_WRITE;
            alu_out_sel  <= write_sel(op_q);
            alu_out_load <= 1'b1;
            done         <= 1'b1;
          end
        end
        ST_SHIFT: begin
          busy         <= 1'b1;
          state        <= ST_WRITE;
          alu_out_sel  <= write_sel(op_q);
          alu_out_load <= 1'b1;
          done         <= 1'b1;
        end
        ST_WRITE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
